// File: rtl/mult_chk_pkg.sv
// Shared definitions for the mult4u fault checker.
//   state_t  : controller states (IDLE, CALC, DONE)
//   PW       : product width for the default operand width
//   step_w() : width of a step counter able to hold 0..width
package mult_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int PW        = 2 * DEF_WIDTH;

  function automatic int step_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Sequential shift-add reference multiplier.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b, clear acc and step (one-cycle strobe)
//   a, b       : unsigned operands, sampled on start
//   acc        : running / final product (2*WIDTH bits)
//   done       : high once WIDTH accumulate steps have completed
// The step count is fixed at WIDTH regardless of operand values.
module mult_shift_add_core
  import mult_chk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 done
);

  localparam int CPW = 2 * WIDTH;
  localparam int SW  = step_w(WIDTH);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH);

  logic [CPW-1:0]   a_ext;
  logic [WIDTH-1:0] b_sh;
  logic [SW-1:0]    step;
  logic             busy;

  assign done = busy && (step == LAST_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ext <= '0;
      b_sh  <= '0;
      step  <= '0;
      busy  <= 1'b0;
      acc   <= '0;
    end else if (start) begin
      a_ext <= {{WIDTH{1'b0}}, a};
      b_sh  <= b;
      step  <= '0;
      busy  <= 1'b1;
      acc   <= '0;
    end else if (busy && !done) begin
      if (b_sh[0]) begin
        acc <= acc + (a_ext << step);
      end
      b_sh <= b_sh >> 1;
      step <= step + 1'b1;
    end
  end

endmodule

// File: rtl/mult4u_fault_checker.sv
// Fault checker for combinational unsigned multipliers.
// Registers an operand pair plus the product from the multiplier under test,
// recomputes the product with a shift-add core, and reports the captured
// product, the reference, a mismatch flag and the XOR syndrome.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : input handshake for {a, b, prod}
//   a, b, prod         : operands and product under test
//   out_valid/out_ready: output handshake
//   out_prod, out_ref  : captured product, reference product
//   out_err            : out_prod != out_ref
//   out_syndrome       : out_prod ^ out_ref
//   err_cnt            : saturating mismatch count (MULT_CHK_ERRCNT_EN only)
// Optional feature macro: MULT_CHK_ERRCNT_EN
//
// state | meaning
// IDLE  | ready for a new triple
// CALC  | shift-add core running WIDTH steps, then results latched
// DONE  | results valid, waiting for out_ready
module mult4u_fault_checker
  import mult_chk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [2*WIDTH-1:0]   out_ref,
  output logic                 out_err,
  output logic [2*WIDTH-1:0]   out_syndrome
`ifdef MULT_CHK_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int TPW = 2 * WIDTH;

  state_t         state, state_nxt;
  logic [TPW-1:0] prod_reg;
  logic [TPW-1:0] acc;
  logic           core_done;
  logic           start;
  logic           load_out;

  mult_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .acc   (acc),
    .done  (core_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (core_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    start     = (state == IDLE) && in_valid;
    load_out  = (state == CALC) && core_done;
  end

  // prod is sampled only at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     prod_reg <= '0;
    else if (start) prod_reg <= prod;
  end

  // Compare is done once, from the settled accumulator, into output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_prod     <= '0;
      out_ref      <= '0;
      out_err      <= 1'b0;
      out_syndrome <= '0;
    end else if (load_out) begin
      out_prod     <= prod_reg;
      out_ref      <= acc;
      out_err      <= (prod_reg != acc);
      out_syndrome <= prod_reg ^ acc;
    end
  end

`ifdef MULT_CHK_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mult4u_fault_checker.sv
module tb_mult4u_fault_checker;

  localparam int W   = 4;
  localparam int ECW = 2;
  localparam int MAX_CNT = (1 << ECW) - 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [2*W-1:0] prod_i;
  logic         out_valid;
  logic         out_ready;
  logic [2*W-1:0] out_prod;
  logic [2*W-1:0] out_ref;
  logic         out_err;
  logic [2*W-1:0] out_syndrome;
`ifdef MULT_CHK_ERRCNT_EN
  logic [ECW-1:0] err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;

  mult4u_fault_checker #(.WIDTH(W), .ERR_CNT_W(ECW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a_i),
    .b            (b_i),
    .prod         (prod_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_prod     (out_prod),
    .out_ref      (out_ref),
    .out_err      (out_err),
    .out_syndrome (out_syndrome)
`ifdef MULT_CHK_ERRCNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] ref_p;
    logic           err;
    logic [2*W-1:0] syn;
  } vec_t;

  vec_t vecs[9];
  vec_t sat_vecs[5];
  int   sat_seq[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_prod", {24'd0, out_prod}, 32'd0);
    check("rst_out_ref", {24'd0, out_ref}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_out_syndrome", {24'd0, out_syndrome}, 32'd0);
`ifdef MULT_CHK_ERRCNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
  endtask

  // Accept a triple, confirm fixed latency, check results; optionally complete handshake.
  task automatic run_triple(input vec_t v, input bit do_hs);
    int  waited;
    bit  early;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a_i = v.a; b_i = v.b; prod_i = v.prod;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_i = ~v.a; b_i = ~v.b; prod_i = ~v.prod;
    check("in_ready_calc", {31'd0, in_ready}, 32'd0);
    early = 1'b0;
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      if (out_valid) early = 1'b1;
    end
    check("no_early_valid", {31'd0, early}, 32'd0);
    @(posedge clk); #1;
    check("out_valid_latency", {31'd0, out_valid}, 32'd1);
    check("out_ref", {24'd0, out_ref}, {24'd0, v.ref_p});
    check("out_prod", {24'd0, out_prod}, {24'd0, v.prod});
    check("out_err", {31'd0, out_err}, {31'd0, v.err});
    check("out_syndrome", {24'd0, out_syndrome}, {24'd0, v.syn});
    if (do_hs) begin
      @(posedge clk); #1;
      check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
      check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
      if (v.err && model_cnt < MAX_CNT) model_cnt++;
`ifdef MULT_CHK_ERRCNT_EN
      check("err_cnt", 32'(err_cnt), 32'(model_cnt));
`endif
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    model_cnt = 0;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bit seen;

    //          a      b      prod    ref     err   syn
    vecs[0] = '{4'd15, 4'd15, 8'd225, 8'd225, 1'b0, 8'h00};
    vecs[1] = '{4'd3,  4'd5,  8'h0D,  8'h0F,  1'b1, 8'h02};
    vecs[2] = '{4'd9,  4'd0,  8'd0,   8'd0,   1'b0, 8'h00};
    vecs[3] = '{4'd0,  4'd15, 8'd0,   8'd0,   1'b0, 8'h00};
    vecs[4] = '{4'd1,  4'd1,  8'd1,   8'd1,   1'b0, 8'h00};
    vecs[5] = '{4'd12, 4'd10, 8'd120, 8'd120, 1'b0, 8'h00};
    vecs[6] = '{4'd7,  4'd6,  8'd43,  8'd42,  1'b1, 8'h01};
    vecs[7] = '{4'd15, 4'd1,  8'hFF,  8'h0F,  1'b1, 8'hF0};
    vecs[8] = '{4'd8,  4'd8,  8'd64,  8'd64,  1'b0, 8'h00};

    sat_vecs[0] = '{4'd3,  4'd5,  8'h0D,  8'h0F,  1'b1, 8'h02};
    sat_vecs[1] = '{4'd9,  4'd9,  8'd80,  8'd81,  1'b1, 8'h01};
    sat_vecs[2] = '{4'd2,  4'd3,  8'd7,   8'd6,   1'b1, 8'h01};
    sat_vecs[3] = '{4'd15, 4'd15, 8'd224, 8'd225, 1'b1, 8'h01};
    sat_vecs[4] = '{4'd4,  4'd4,  8'd0,   8'd16,  1'b1, 8'h10};
    sat_seq = '{1, 2, 3, 3, 3};

    rst_n = 1'b0;
    in_valid = 1'b0;
    a_i = '0; b_i = '0; prod_i = '0;
    out_ready = 1'b1;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_release", {31'd0, in_ready}, 32'd1);

    for (int k = 0; k < 9; k++) run_triple(vecs[k], 1'b1);

    // Backpressure: hold DONE for 10 cycles while offering a new triple
    out_ready = 1'b0;
    run_triple('{4'd5, 4'd6, 8'd30, 8'd30, 1'b0, 8'h00}, 1'b0);
    in_valid = 1'b1;
    a_i = 4'd1; b_i = 4'd1; prod_i = 8'd99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_ref", {24'd0, out_ref}, 32'd30);
      check("bp_out_prod", {24'd0, out_prod}, 32'd30);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    run_triple(vecs[4], 1'b1);

    // Reset during the second CALC cycle of 7*6
    in_valid = 1'b1;
    a_i = 4'd7; b_i = 4'd6; prod_i = 8'd42;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    pulse_reset();
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_mid_no_valid", {31'd0, seen}, 32'd0);
    run_triple('{4'd2, 4'd2, 8'd4, 8'd4, 1'b0, 8'h00}, 1'b1);

`ifdef MULT_CHK_ERRCNT_EN
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      run_triple(sat_vecs[k], 1'b1);
      check("err_cnt_sat_seq", 32'(err_cnt), 32'(sat_seq[k]));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
